// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: decode-to-execute pipeline register bus (inputs from decode, registered outputs to execute)
interface id_ex_stage_reg_if;
  logic        freeze;
  logic        flush;
  logic        in_valid;
  logic [3:0]  exe_cmd_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        wb_en_in;
  logic        b_in;
  logic        s_in;
  logic        imm_in;
  logic [31:0] pc_in;
  logic [31:0] val_rn_in;
  logic [31:0] val_rm_in;
  logic [3:0]  src1_in;
  logic [3:0]  src2_in;
  logic [3:0]  dest_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  status_in;
  logic        wb_wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        out_valid;
  logic [3:0]  exe_cmd_out;
  logic        mem_r_en_out;
  logic        mem_w_en_out;
  logic        wb_en_out;
  logic        b_out;
  logic        s_out;
  logic        imm_out;
  logic [31:0] pc_out;
  logic [31:0] val_rn_out;
  logic [31:0] val_rm_out;
  logic [3:0]  src1_out;
  logic [3:0]  src2_out;
  logic [3:0]  dest_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  logic [3:0]  status_out;
  modport master (
    output freeze, flush, in_valid, exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, imm_in,
           pc_in, val_rn_in, val_rm_in, src1_in, src2_in, dest_in, shift_operand_in, signed_imm_24_in,
           status_in, wb_wb_en, wb_dest, wb_value,
    input  out_valid, exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, imm_out,
           pc_out, val_rn_out, val_rm_out, src1_out, src2_out, dest_out, shift_operand_out,
           signed_imm_24_out, status_out
  );
  modport slave (
    input  freeze, flush, in_valid, exe_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, imm_in,
           pc_in, val_rn_in, val_rm_in, src1_in, src2_in, dest_in, shift_operand_in, signed_imm_24_in,
           status_in, wb_wb_en, wb_dest, wb_value,
    output out_valid, exe_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, imm_out,
           pc_out, val_rn_out, val_rm_out, src1_out, src2_out, dest_out, shift_operand_out,
           signed_imm_24_out, status_out
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with freeze/flush, saturating event counters; define ID_EX_WB_BYPASS_EN for write-back bypass at capture
module id_ex_stage_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_stage_reg_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic              w_byp_rn;
  logic              w_byp_rm;
  logic [31:0]       w_rn;
  logic [31:0]       w_rm;
  logic [9:0]        w_ctrl_in;
  logic [147:0]      w_data_in;
  logic              r_valid;
  logic [9:0]        r_ctrl;
  logic [147:0]      r_data;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
`ifdef ID_EX_WB_BYPASS_EN
  assign w_byp_rn = bus.wb_wb_en && (bus.wb_dest == bus.src1_in);
  assign w_byp_rm = bus.wb_wb_en && (bus.wb_dest == bus.src2_in);
`else
  assign w_byp_rn = 1'b0;
  assign w_byp_rm = 1'b0;
`endif
  assign w_rn      = w_byp_rn ? bus.wb_value : bus.val_rn_in;
  assign w_rm      = w_byp_rm ? bus.wb_value : bus.val_rm_in;
  assign w_ctrl_in = {bus.exe_cmd_in, bus.mem_r_en_in, bus.mem_w_en_in, bus.wb_en_in, bus.b_in, bus.s_in, bus.imm_in};
  assign w_data_in = {bus.pc_in, w_rn, w_rm, bus.src1_in, bus.src2_in, bus.dest_in,
                      bus.shift_operand_in, bus.signed_imm_24_in, bus.status_in};
  // pipeline register: flush inserts an all-zero bubble, freeze holds, otherwise capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (!bus.freeze) begin
      r_valid <= bus.in_valid;
      r_ctrl  <= w_ctrl_in;
      r_data  <= w_data_in;
    end
  end
  // stall and flush event counters, saturating at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.freeze && !bus.flush && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (bus.flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
  assign bus.out_valid = r_valid;
  assign {bus.exe_cmd_out, bus.mem_r_en_out, bus.mem_w_en_out, bus.wb_en_out, bus.b_out, bus.s_out, bus.imm_out} = r_ctrl;
  assign {bus.pc_out, bus.val_rn_out, bus.val_rm_out, bus.src1_out, bus.src2_out, bus.dest_out,
          bus.shift_operand_out, bus.signed_imm_24_out, bus.status_out} = r_data;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall and flush event counters.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 freeze  input  1  hazard stall: hold all pipeline outputs.
REQ-005 flush  input  1  branch taken: insert a bubble.
REQ-006 in_valid  input  1  decode stage presents a valid instruction.
REQ-007 exe_cmd_in  input  4  ALU command.
REQ-008 mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, imm_in  input  1 each  decoded control bits.
REQ-009 pc_in  input  32  PC+4 of the instruction.
REQ-010 val_rn_in, val_rm_in  input  32 each  register-file read data for src1_in and src2_in.
REQ-011 src1_in, src2_in, dest_in  input  4 each  source and destination register indices.
REQ-012 shift_operand_in  input  12  shifter operand field.
REQ-013 signed_imm_24_in  input  24  branch offset.
REQ-014 status_in  input  4  NZCV flags.
REQ-015 wb_wb_en, wb_dest, wb_value  input  1/4/32  current write-back port.
REQ-016 Outputs: each *_in field has a registered *_out counterpart of the same width, plus out_valid (1 bit).
REQ-017 stall_cnt, flush_cnt  output  CNT_W each  event counters.

Function
REQ-018 The block SHALL capture all *_in fields into *_out on a rising edge when flush=0 and freeze=0, with a latency of one cycle; out_valid SHALL equal in_valid.
REQ-019 When freeze=1 and flush=0, every *_out and out_valid SHALL hold its previous value.
REQ-020 When flush=1, the block SHALL clear all control outputs (exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, imm) and out_valid to 0 on the next edge, regardless of freeze; flush has priority over freeze.
REQ-021 During a flush, the data outputs (pc, val_rn, val_rm, indices, shift_operand, signed_imm_24, status) SHALL also clear to 0.
REQ-022 stall_cnt SHALL increment by 1 on every edge with freeze=1 and flush=0.
REQ-023 flush_cnt SHALL increment by 1 on every edge with flush=1.
REQ-024 Both counters SHALL saturate at all-ones and SHALL NOT wrap around.
REQ-025 The block SHALL be purely registered; no *_out depends combinationally on any input.
REQ-026 A bypass hit (see Configuration) that occurs while freeze=1 SHALL NOT alter the held values.

Reset
REQ-027 While rst=1, every output, including out_valid, stall_cnt and flush_cnt, SHALL be 0 immediately, without waiting for a clock edge.
REQ-028 A rst assertion mid-stall or mid-flush SHALL discard the held instruction; the first capture after rst deasserts SHALL follow REQ-018.

Configuration
REQ-029 Macro ID_EX_WB_BYPASS_EN controls write-back bypassing at capture.
REQ-030 When ID_EX_WB_BYPASS_EN is defined and a capture occurs with wb_wb_en=1 and wb_dest==src1_in, val_rn_out SHALL take wb_value instead of val_rn_in.
REQ-031 Under the same conditions, if wb_dest==src2_in, val_rm_out SHALL take wb_value; both operands SHALL be bypassed when both match.
REQ-032 When ID_EX_WB_BYPASS_EN is undefined, val_rn_out and val_rm_out SHALL always capture val_rn_in and val_rm_in, and wb_* SHALL be ignored.

Verification
REQ-033 Capture: rst pulse, then in_valid=1, exe_cmd_in=4'h2, val_rn_in=32'h5, pc_in=32'h8 for one edge -> next cycle out_valid=1, exe_cmd_out=2, val_rn_out=5, pc_out=8.
REQ-034 Freeze: capture pc_in=32'h10, then freeze=1 for 3 edges with pc_in=32'h14 -> pc_out stays 32'h10 and stall_cnt=3.
REQ-035 Flush beats freeze: with wb_en_out=1 held, assert freeze=1 and flush=1 together -> next cycle wb_en_out=0, out_valid=0, flush_cnt=1, stall_cnt unchanged.
REQ-036 Saturation: with CNT_W=4, hold freeze=1 for 20 edges -> stall_cnt=4'hF.
REQ-037 Bypass, macro defined: src1_in=src2_in=4'd3, val_rn_in=val_rm_in=32'h1, wb_wb_en=1, wb_dest=3, wb_value=32'hAB -> val_rn_out=val_rm_out=32'hAB. With the macro undefined, the same stimulus -> both outputs 32'h1.
REQ-038 Asynchronous reset: assert rst between clock edges while out_valid=1 and stall_cnt=5 -> all outputs 0 before the next rising edge.
